// File: rtl/ip_tx_arbiter.sv
// rtl/ip_tx_arbiter.sv - packet-granular 2:1 AXIS arbiter in front of the IP TX datapath
// Optional per-source packet counters: define IP_TX_ARB_STATS_EN.
module ip_tx_arbiter #(
  parameter int P_PRIO_MODE = 0,
  parameter int P_USER_W    = 56
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [63:0]         s0_axis_data,
  input  logic [P_USER_W-1:0] s0_axis_user,
  input  logic [7:0]          s0_axis_keep,
  input  logic                s0_axis_last,
  input  logic                s0_axis_valid,
  output logic                s0_axis_ready,
  input  logic [63:0]         s1_axis_data,
  input  logic [P_USER_W-1:0] s1_axis_user,
  input  logic [7:0]          s1_axis_keep,
  input  logic                s1_axis_last,
  input  logic                s1_axis_valid,
  output logic                s1_axis_ready,
  output logic [63:0]         m_axis_ip_data,
  output logic [P_USER_W-1:0] m_axis_ip_user,
  output logic [7:0]          m_axis_ip_keep,
  output logic                m_axis_ip_last,
  output logic                m_axis_ip_valid,
  input  logic                m_axis_ip_ready,
`ifdef IP_TX_ARB_STATS_EN
  output logic [15:0]         o_pkt_cnt0,
  output logic [15:0]         o_pkt_cnt1,
`endif
  output logic [1:0]          o_grant,
  output logic                o_busy
);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t              state;
  logic                rr_ptr;
  logic [P_USER_W-1:0] user_q;
  logic                pick1;
  logic                pkt_done;

  // rr_ptr names the source preferred on a tie; it only matters in round-robin mode.
  always_comb begin
    pick1 = s1_axis_valid & (~s0_axis_valid | ((P_PRIO_MODE == 0) & rr_ptr));
  end

  always_comb begin
    m_axis_ip_data  = '0;
    m_axis_ip_keep  = '0;
    m_axis_ip_last  = 1'b0;
    m_axis_ip_valid = 1'b0;
    s0_axis_ready   = 1'b0;
    s1_axis_ready   = 1'b0;
    m_axis_ip_user  = o_busy ? user_q : '0;
    if (o_grant[0]) begin
      m_axis_ip_data  = s0_axis_data;
      m_axis_ip_keep  = s0_axis_keep;
      m_axis_ip_last  = s0_axis_last;
      m_axis_ip_valid = s0_axis_valid;
      s0_axis_ready   = m_axis_ip_ready;
    end else if (o_grant[1]) begin
      m_axis_ip_data  = s1_axis_data;
      m_axis_ip_keep  = s1_axis_keep;
      m_axis_ip_last  = s1_axis_last;
      m_axis_ip_valid = s1_axis_valid;
      s1_axis_ready   = m_axis_ip_ready;
    end
  end

  assign pkt_done = m_axis_ip_valid & m_axis_ip_ready & m_axis_ip_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      o_grant <= 2'b00;
      o_busy  <= 1'b0;
      user_q  <= '0;
      rr_ptr  <= 1'b0;
`ifdef IP_TX_ARB_STATS_EN
      o_pkt_cnt0 <= 16'd0;
      o_pkt_cnt1 <= 16'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (s0_axis_valid | s1_axis_valid) begin
            state   <= S_XFER;
            o_busy  <= 1'b1;
            o_grant <= pick1 ? 2'b10 : 2'b01;
            user_q  <= pick1 ? s1_axis_user : s0_axis_user;
          end
        end
        S_XFER: begin
          if (pkt_done) begin
            state   <= S_IDLE;
            o_busy  <= 1'b0;
            o_grant <= 2'b00;
            rr_ptr  <= ~o_grant[1];
`ifdef IP_TX_ARB_STATS_EN
            if (o_grant[1]) o_pkt_cnt1 <= o_pkt_cnt1 + 16'd1;
            else            o_pkt_cnt0 <= o_pkt_cnt0 + 16'd1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// tb/tb_ip_tx_arbiter.sv - directed self-checking bench for ip_tx_arbiter
module tb_ip_tx_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [63:0] s0_data = '0, s1_data = '0;
  logic [55:0] s0_user = '0, s1_user = '0;
  logic [7:0]  s0_keep = '0, s1_keep = '0;
  logic        s0_last = 1'b0, s1_last = 1'b0;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic        s0_ready, s1_ready;
  logic [63:0] m_data;
  logic [55:0] m_user;
  logic [7:0]  m_keep;
  logic        m_last, m_valid;
  logic        m_ready = 1'b0;
  logic [1:0]  grant;
  logic        busy;
  logic [63:0] p_data;
  logic [55:0] p_user;
  logic [7:0]  p_keep;
  logic        p_last, p_valid, p_s0_ready, p_s1_ready, p_busy;
  logic [1:0]  p_grant;
`ifdef IP_TX_ARB_STATS_EN
  logic [15:0] cnt0, cnt1, p_cnt0, p_cnt1;
`endif

  int tests = 0;
  int failed = 0;
  int b;

  always #5 i_clk = ~i_clk;

  ip_tx_arbiter #(.P_PRIO_MODE(0), .P_USER_W(56)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s0_axis_data(s0_data), .s0_axis_user(s0_user), .s0_axis_keep(s0_keep),
    .s0_axis_last(s0_last), .s0_axis_valid(s0_valid), .s0_axis_ready(s0_ready),
    .s1_axis_data(s1_data), .s1_axis_user(s1_user), .s1_axis_keep(s1_keep),
    .s1_axis_last(s1_last), .s1_axis_valid(s1_valid), .s1_axis_ready(s1_ready),
    .m_axis_ip_data(m_data), .m_axis_ip_user(m_user), .m_axis_ip_keep(m_keep),
    .m_axis_ip_last(m_last), .m_axis_ip_valid(m_valid), .m_axis_ip_ready(m_ready),
`ifdef IP_TX_ARB_STATS_EN
    .o_pkt_cnt0(cnt0), .o_pkt_cnt1(cnt1),
`endif
    .o_grant(grant), .o_busy(busy)
  );

  ip_tx_arbiter #(.P_PRIO_MODE(1), .P_USER_W(56)) dut_prio (
    .i_clk(i_clk), .i_rst(i_rst),
    .s0_axis_data(s0_data), .s0_axis_user(s0_user), .s0_axis_keep(s0_keep),
    .s0_axis_last(s0_last), .s0_axis_valid(s0_valid), .s0_axis_ready(p_s0_ready),
    .s1_axis_data(s1_data), .s1_axis_user(s1_user), .s1_axis_keep(s1_keep),
    .s1_axis_last(s1_last), .s1_axis_valid(s1_valid), .s1_axis_ready(p_s1_ready),
    .m_axis_ip_data(p_data), .m_axis_ip_user(p_user), .m_axis_ip_keep(p_keep),
    .m_axis_ip_last(p_last), .m_axis_ip_valid(p_valid), .m_axis_ip_ready(m_ready),
`ifdef IP_TX_ARB_STATS_EN
    .o_pkt_cnt0(p_cnt0), .o_pkt_cnt1(p_cnt1),
`endif
    .o_grant(p_grant), .o_busy(p_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    // Test 1: reset state, then a 4-beat src0 packet
    tick();
    tick();
    i_rst = 1'b0;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_s0ready", s0_ready, 1'b0);
    s0_valid = 1'b1; s0_data = 64'h100; s0_user = {16'd32, 40'h0};
    s0_last = 1'b0; s0_keep = 8'h00; m_ready = 1'b1;
    #1;
    chk("t1_pre_grant", grant, 2'b00);
    chk("t1_pre_ready", s0_ready, 1'b0);
    tick();
    chk("t1_grant", grant, 2'b01);
    chk("t1_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      s0_data = 64'h100 + 64'(i);
      s0_last = (i == 3);
      s0_keep = (i == 3) ? 8'hFF : 8'h00;
      if (i > 0) s0_user = 56'hDEAD;
      #1;
      chk("t1_data", m_data, 64'h100 + 64'(i));
      chk("t1_last", m_last, (i == 3) ? 1'b1 : 1'b0);
      chk("t1_keep", m_keep, (i == 3) ? 8'hFF : 8'h00);
      chk("t1_user", m_user, {16'd32, 40'h0});
      chk("t1_ready", s0_ready, 1'b1);
      tick();
    end
    s0_valid = 1'b0; s0_last = 1'b0;
    #1;
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_idle_valid", m_valid, 1'b0);

    // Test 2: round-robin with both sources always requesting single-beat packets
    i_rst = 1'b1;
    s0_valid = 1'b1; s0_last = 1'b1; s0_data = 64'hA0;
    s1_valid = 1'b1; s1_last = 1'b1; s1_data = 64'hB0;
    tick();
    i_rst = 1'b0;
    for (int p = 0; p < 6; p++) begin
      tick();
      chk("t2_grant", grant, (p % 2 == 0) ? 2'b01 : 2'b10);
      chk("t2_data", m_data, (p % 2 == 0) ? 64'hA0 : 64'hB0);
      chk("t2_s0ready", s0_ready, (p % 2 == 0) ? 1'b1 : 1'b0);
      chk("t2_s1ready", s1_ready, (p % 2 == 0) ? 1'b0 : 1'b1);
      tick();
      chk("t2_bubble", grant, 2'b00);
    end

    // Test 3: fixed priority starves src1
    do_reset();
    for (int p = 0; p < 3; p++) begin
      tick();
      chk("t3_grant", p_grant, 2'b01);
      chk("t3_s1ready", p_s1_ready, 1'b0);
      chk("t3_data", p_data, 64'hA0);
      tick();
      chk("t3_bubble", p_grant, 2'b00);
    end
    s0_valid = 1'b0; s1_valid = 1'b0;

    // Test 4: src1 packet with ready toggling and a valid gap; src0 waits
    do_reset();
    s1_valid = 1'b1; s1_data = 64'h40; s1_last = 1'b0;
    s0_last = 1'b0;
    tick();
    chk("t4_grant", grant, 2'b10);
    s0_valid = 1'b1; s0_data = 64'hC0;
    b = 0;
    for (int i = 0; i < 20 && b < 4; i++) begin
      m_ready  = (i % 2 == 0) || (i >= 6);
      s1_valid = !(i == 2 || i == 3);
      s1_data  = 64'h40 + 64'(b);
      s1_last  = (b == 3);
      #1;
      chk("t4_mvalid", m_valid, s1_valid);
      if (s1_valid) chk("t4_data", m_data, 64'h40 + 64'(b));
      chk("t4_s0ready", s0_ready, 1'b0);
      chk("t4_s1ready", s1_ready, m_ready);
      chk("t4_hold", grant, 2'b10);
      if (s1_valid && m_ready) b++;
      tick();
    end
    chk("t4_beats", 64'(b), 64'd4);
    s1_valid = 1'b0; s1_last = 1'b0; m_ready = 1'b1;
    #1;
    chk("t4_idle", grant, 2'b00);
    tick();
    chk("t4_next_grant", grant, 2'b01);
    chk("t4_next_data", m_data, 64'hC0);
    s0_last = 1'b1;
    tick();
    s0_valid = 1'b0; s0_last = 1'b0;

    // Test 5: reset on beat 2 of a 5-beat src0 packet
    do_reset();
    s0_valid = 1'b1; s0_user = 56'h55; s0_data = 64'h200;
    tick();
    chk("t5_grant", grant, 2'b01);
    for (int i = 0; i < 2; i++) begin
      s0_data = 64'h200 + 64'(i);
      tick();
    end
    s0_data = 64'h202;
    i_rst = 1'b1;
    tick();
    chk("t5_rst_grant", grant, 2'b00);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_mvalid", m_valid, 1'b0);
    chk("t5_rst_muser", m_user, 56'h0);
    chk("t5_rst_s0ready", s0_ready, 1'b0);
    i_rst = 1'b0;
    s0_data = 64'h300; s0_user = 56'h77;
    #1;
    chk("t5_pre_grant", grant, 2'b00);
    tick();
    chk("t5_regrant", grant, 2'b01);
    chk("t5_redata", m_data, 64'h300);
    chk("t5_reuser", m_user, 56'h77);
    s0_last = 1'b1;
    tick();
    s0_valid = 1'b0; s0_last = 1'b0;
    #1;
    chk("t5_done", grant, 2'b00);

`ifdef IP_TX_ARB_STATS_EN
    // Packet counters: only src1 sends
    do_reset();
    s1_valid = 1'b1; s1_last = 1'b1;
    for (int p = 0; p < 5; p++) begin
      tick();
      tick();
    end
    s1_valid = 1'b0;
    #1;
    chk("st_cnt1", cnt1, 16'd5);
    chk("st_cnt0", cnt0, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
